// File: rtl/move_timer_pkg.sv
// Shared definitions for the move timer: FSM state type and default sizing.
package move_timer_pkg;

   typedef enum logic {
      STOPPED = 1'b0,
      RUNNING = 1'b1
   } state_t;

   localparam int unsigned CNT_W          = 24;
   localparam int unsigned MISS_W         = 8;
   localparam logic [23:0] DEFAULT_PERIOD = 24'd5_000_000;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] q
);

   always_ff @(posedge clk) begin
      if (clr)
         q <= '0;
      else if (inc && (q != '1))
         q <= q + W'(1);
   end

endmodule

// File: rtl/move_timer.sv
// Periodic move timer: raises a held move request each period and counts
// expiries that land while the previous request is still unacknowledged.
module move_timer #(
   parameter int unsigned     CNT_W          = move_timer_pkg::CNT_W,
   parameter logic [CNT_W-1:0] DEFAULT_PERIOD = CNT_W'(move_timer_pkg::DEFAULT_PERIOD),
   parameter int unsigned     MISS_W         = move_timer_pkg::MISS_W
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              run,
   input  logic              we,
   input  logic [CNT_W-1:0]  wdata,
   input  logic              ack,
   input  logic              miss_clr,
   output logic              move,
   output logic              tick,
   output logic [MISS_W-1:0] miss
);

   import move_timer_pkg::*;

   state_t           state, state_nx;
   logic             counting;
   logic [CNT_W-1:0] period;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] last;
   logic             expire;
   logic             miss_inc;

   always_ff @(posedge clk) begin
      if (clr)
         state <= STOPPED;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         STOPPED: if (run)  state_nx = RUNNING;
         RUNNING: if (!run) state_nx = STOPPED;
         default:           state_nx = STOPPED;
      endcase
   end

   always_comb begin
      counting = (state == RUNNING);
   end

   // period 0 wraps like period 1; a reload in the same cycle cancels the expiry
   always_comb begin
      last     = (period == '0) ? '0 : period - CNT_W'(1);
      expire   = counting && (cnt == last) && !we;
      miss_inc = expire && move && !ack;
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         period <= DEFAULT_PERIOD;
         cnt    <= '0;
         tick   <= 1'b0;
         move   <= 1'b0;
      end else begin
         tick <= expire;
         if (we) begin
            period <= wdata;
            cnt    <= '0;
         end else if (counting) begin
            cnt <= expire ? '0 : cnt + CNT_W'(1);
         end
         if (expire)
            move <= 1'b1;
         else if (ack)
            move <= 1'b0;
      end
   end

   sat_counter #(
      .W(MISS_W)
   ) u_miss (
      .clk(clk),
      .clr(clr | miss_clr),
      .inc(miss_inc),
      .q  (miss)
   );

endmodule
